cd_101: RTL and testbench

CD_101 -- requirements
Module: cd_101

---
 rtl/cd_101.sv | 81 ++++++++
 tb/tb_cd_101.sv | 110 +++++++++++
 2 files changed

// File: rtl/cd_101.sv
// Serial pattern detector: Moore FSM tracking the longest matched prefix of PATTERN,
// with a one-cycle DET state per detection (overlapping or non-overlapping).
module cd_101 #(
  parameter int unsigned               PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0]    PATTERN     = 3'b101,
  parameter int unsigned               OVERLAP     = 0
) (
  input  logic clk,
  input  logic signal,
  output logic out,
  input  logic rst
);

  // MATCH carries the prefix length in plen (1..PATTERN_LEN-1); for 101 these are S1/S10.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    DET   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [3:0]  plen, plen_n;
  logic        bit_in;
  logic        valid;
  int unsigned k;
  int unsigned nl;

  // Longest suffix of (prefix_k followed by b) that is also a prefix of PATTERN.
  function automatic int unsigned next_len(input int unsigned kk, input logic b);
    int unsigned pat;
    int unsigned cand;
    pat      = 32'(PATTERN);
    cand     = ((pat >> (PATTERN_LEN - kk)) << 1) | 32'(b);
    next_len = 0;
    for (int unsigned j = 1; j <= PATTERN_LEN; j++) begin
      if ((j <= kk + 1) && ((cand & ((32'd1 << j) - 1)) == (pat >> (PATTERN_LEN - j))))
        next_len = j;
    end
  endfunction

  assign bit_in = (signal === 1'b1);

  always_comb begin
    state_n = IDLE;
    plen_n  = '0;
    valid   = 1'b1;
    k       = 0;
    nl      = 0;
    case (state)
      IDLE:  k = 0;
      MATCH: begin
        k = 32'(plen);
        if (k == 0 || k >= PATTERN_LEN) valid = 1'b0;
      end
      DET:   k = (OVERLAP != 0) ? PATTERN_LEN : 0;
      default: valid = 1'b0;
    endcase
    if (valid) begin
      nl = next_len(k, bit_in);
      if (nl == PATTERN_LEN) begin
        state_n = DET;
      end else if (nl != 0) begin
        state_n = MATCH;
        plen_n  = 4'(nl);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      plen  <= '0;
    end else begin
      state <= state_n;
      plen  <= plen_n;
    end
  end

  assign out = (state == DET);

endmodule

// File: tb/tb_cd_101.sv
// Bench for cd_101: directed sequences then random bits, with a history-based detection model
// for a non-overlapping and an overlapping instance.
module tb_cd_101;

  localparam int unsigned L   = 3;
  localparam int unsigned PAT = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signal = 1'b0;
  logic out_no, out_ov;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  int unsigned hist_no = 0, hlen_no = 0;
  int unsigned hist_ov = 0, hlen_ov = 0;
  logic        exp_no = 1'b0, exp_ov = 1'b0;

  always #5 clk = ~clk;

  cd_101 #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(0)) u_no (
    .clk(clk), .signal(signal), .out(out_no), .rst(rst)
  );

  cd_101 #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1)) u_ov (
    .clk(clk), .signal(signal), .out(out_ov), .rst(rst)
  );

  // Detection = last L bits received since reset (non-overlap: since last detection) equal PAT.
  task automatic model(input logic r, input logic s);
    if (r) begin
      hist_no = 0; hlen_no = 0; exp_no = 1'b0;
      hist_ov = 0; hlen_ov = 0; exp_ov = 1'b0;
    end else begin
      hist_no = (hist_no << 1) | 32'(s); hlen_no++;
      hist_ov = (hist_ov << 1) | 32'(s); hlen_ov++;
      exp_no = (hlen_no >= L) && ((hist_no & ((32'd1 << L) - 1)) == PAT);
      exp_ov = (hlen_ov >= L) && ((hist_ov & ((32'd1 << L) - 1)) == PAT);
      if (exp_no) begin
        hist_no = 0; hlen_no = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input string tag);
    @(negedge clk);
    rst    = r;
    signal = s;
    @(posedge clk);
    model(r, s);
    #1;
    tests++;
    assert (out_no === exp_no) else begin
      failed++;
      $error("FAIL %s nonoverlap: out=%b expected=%b", tag, out_no, exp_no);
    end
    tests++;
    assert (out_ov === exp_ov) else begin
      failed++;
      $error("FAIL %s overlap: out=%b expected=%b", tag, out_ov, exp_ov);
    end
  endtask

  initial begin
    logic [15:0] seq;
    // reset with signal high
    step(1'b1, 1'b1, "reset1");
    step(1'b1, 1'b1, "reset2");
    // basic 101 then trailing bit
    seq = 16'b1010; for (int i = 3; i >= 0; i--) step(1'b0, seq[i], "basic");
    step(1'b1, 1'b0, "rst");
    // non-overlap vs overlap 10101
    seq = 16'b10101; for (int i = 4; i >= 0; i--) step(1'b0, seq[i], "overlap");
    step(1'b1, 1'b0, "rst");
    // back-to-back 101101
    seq = 16'b101101; for (int i = 5; i >= 0; i--) step(1'b0, seq[i], "b2b");
    step(1'b1, 1'b0, "rst");
    // prefix recovery 1101
    seq = 16'b1101; for (int i = 3; i >= 0; i--) step(1'b0, seq[i], "prefix");
    step(1'b1, 1'b0, "rst");
    // no false match 1001
    seq = 16'b1001; for (int i = 3; i >= 0; i--) step(1'b0, seq[i], "nofalse");
    step(1'b1, 1'b0, "rst");
    // reset mid-sequence
    step(1'b0, 1'b1, "midrst");
    step(1'b0, 1'b0, "midrst");
    step(1'b1, 1'b1, "midrst");
    step(1'b0, 1'b1, "midrst");
    step(1'b0, 1'b0, "midrst");
    step(1'b1, 1'b0, "rst");
    // reset on the edge sampling the final 1
    step(1'b0, 1'b1, "rstpulse");
    step(1'b0, 1'b0, "rstpulse");
    step(1'b1, 1'b1, "rstpulse");
    step(1'b0, 1'b0, "rstpulse");
    // random bits with rare resets
    for (int i = 0; i < 200; i++)
      step(logic'($urandom_range(0, 49) == 0), logic'($urandom_range(0, 1)), "random");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
